// File: rtl/ram_arbiter_2.sv
// ram_arbiter_2: two-port RAM arbiter, IDLE/ACC/RSP FSM, round-robin ties.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority to port 0.
module ram_arbiter_2 #(
  parameter int adds = 10,
  parameter int wsize = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic [adds-1:0]  addr0,
  input  logic [adds-1:0]  addr1,
  input  logic [wsize-1:0] wdata0,
  input  logic [wsize-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [wsize-1:0] rdata0,
  output logic [wsize-1:0] rdata1,
  output logic             ram_cs,
  output logic             ram_wr,
  output logic [adds-1:0]  ram_addr,
  output logic [wsize-1:0] ram_din,
  input  logic [wsize-1:0] ram_dout
);
  typedef enum logic [1:0] {IDLE, ACC, RSP} state_e;
  state_e state_q, state_d;
  logic win_q, win_d, wr_q, wr_d, pick, acc, rsp;
  logic [adds-1:0] addr_q, addr_d;
  logic [wsize-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign pick = !req0;
`else
  logic last_q, last_d;
  assign pick = (req0 && req1) ? !last_q : req1;
  assign last_d = (state_q == ACC) ? win_q : last_q;
  always_ff @(posedge clk)
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
`endif
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (req0 || req1) begin
        state_d = ACC;
        win_d = pick;
        wr_d = pick ? wr1 : wr0;
        addr_d = pick ? addr1 : addr0;
        wdata_d = pick ? wdata1 : wdata0;
      end
      ACC: begin
        state_d = wr_q ? IDLE : RSP;
        rdata0_d = (!wr_q && !win_q) ? ram_dout : rdata0_q;
        rdata1_d = (!wr_q && win_q) ? ram_dout : rdata1_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      win_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  // rst masks the strobes so an aborted access never shows a gnt or rvalid
  assign acc = !rst && state_q == ACC;
  assign rsp = !rst && state_q == RSP;
  assign gnt0 = acc && !win_q;
  assign gnt1 = acc && win_q;
  assign rvalid0 = rsp && !win_q;
  assign rvalid1 = rsp && win_q;
  assign ram_cs = acc;
  assign ram_wr = acc && wr_q;
  assign ram_addr = addr_q;
  assign ram_din = wdata_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
endmodule

// File: tb/tb_ram_arbiter_2.sv
// tb_ram_arbiter_2: table-driven bench for ram_arbiter_2 with a behavioural RAM.
module tb_ram_arbiter_2;
  logic clk = 1'b0;
  logic rst, req0, req1, wr0, wr1;
  logic [9:0] addr0, addr1, ram_addr;
  logic [7:0] wdata0, wdata1, rdata0, rdata1, ram_din, ram_dout;
  logic gnt0, gnt1, rvalid0, rvalid1, ram_cs, ram_wr;
  logic [7:0] mem [1024];
  logic [39:0] outs;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic rst, r0, w0;
    logic [9:0] a0;
    logic [7:0] d0;
    logic r1, w1;
    logic [9:0] a1;
    logic [7:0] d1;
    logic [39:0] exp;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  ram_arbiter_2 #(.adds(10), .wsize(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .ram_cs(ram_cs), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_cs && ram_wr) mem[ram_addr] <= ram_din;
  assign outs = {gnt0, gnt1, rvalid0, rvalid1, ram_cs, ram_wr, ram_addr, ram_din, rdata0, rdata1};

  function automatic logic [39:0] ex(logic g0, g1, v0, v1, cs, wr, logic [9:0] ra,
                                     logic [7:0] rd, q0, q1);
    return {g0, g1, v0, v1, cs, wr, ra, rd, q0, q1};
  endfunction

  function automatic void add(logic rs, r0, w0, logic [9:0] a0, logic [7:0] d0,
                              logic r1, w1, logic [9:0] a1, logic [7:0] d1, logic [39:0] e);
    vq.push_back('{rs, r0, w0, a0, d0, r1, w1, a1, d1, e});
  endfunction

  task automatic chk(string nm, logic [39:0] act, logic [39:0] e);
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic drive(logic rs, r0, w0, logic [9:0] a0, logic [7:0] d0,
                       logic r1, w1, logic [9:0] a1, logic [7:0] d1);
    rst = rs; req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) + 8'h40;
    // reset and write-then-read on port 0
    add(1, 0,0,0,0,     0,0,0,0,     ex(0,0,0,0,0,0, 0,0,0,0));
    add(0, 0,0,0,0,     0,0,0,0,     ex(0,0,0,0,0,0, 0,0,0,0));
    add(0, 1,1,5,8'hA5, 0,0,0,0,     ex(1,0,0,0,1,1, 5,8'hA5,0,0));
    add(0, 0,0,0,0,     0,0,0,0,     ex(0,0,0,0,0,0, 5,8'hA5,0,0));
    add(0, 1,0,5,0,     0,0,0,0,     ex(1,0,0,0,1,0, 5,0,0,0));
    add(0, 0,0,0,0,     0,0,0,0,     ex(0,0,1,0,0,0, 5,0,8'hA5,0));
    add(0, 0,0,0,0,     0,0,0,0,     ex(0,0,0,0,0,0, 5,0,8'hA5,0));
    // tie after reset: gnt0, gnt1, gnt0, gnt1, one read per 3 cycles
    add(1, 0,0,0,0,     0,0,0,0,     ex(0,0,0,0,0,0, 0,0,0,0));
    add(0, 1,0,1,0,     1,0,2,0,     ex(1,0,0,0,1,0, 1,0,0,0));
    add(0, 1,0,1,0,     1,0,2,0,     ex(0,0,1,0,0,0, 1,0,8'h41,0));
    add(0, 1,0,1,0,     1,0,2,0,     ex(0,0,0,0,0,0, 1,0,8'h41,0));
    add(0, 1,0,1,0,     1,0,2,0,     ex(0,1,0,0,1,0, 2,0,8'h41,0));
    add(0, 1,0,1,0,     1,0,2,0,     ex(0,0,0,1,0,0, 2,0,8'h41,8'h42));
    add(0, 1,0,1,0,     1,0,2,0,     ex(0,0,0,0,0,0, 2,0,8'h41,8'h42));
    add(0, 1,0,1,0,     1,0,2,0,     ex(1,0,0,0,1,0, 1,0,8'h41,8'h42));
    add(0, 1,0,1,0,     1,0,2,0,     ex(0,0,1,0,0,0, 1,0,8'h41,8'h42));
    add(0, 1,0,1,0,     1,0,2,0,     ex(0,0,0,0,0,0, 1,0,8'h41,8'h42));
    add(0, 1,0,1,0,     1,0,2,0,     ex(0,1,0,0,1,0, 2,0,8'h41,8'h42));
    add(0, 0,0,0,0,     0,0,0,0,     ex(0,0,0,1,0,0, 2,0,8'h41,8'h42));
    add(0, 0,0,0,0,     0,0,0,0,     ex(0,0,0,0,0,0, 2,0,8'h41,8'h42));
    // port 1 alone: 4 writes, gnt1 every 2 cycles
    add(0, 0,0,0,0,     1,1,10'h100,8'h11, ex(0,1,0,0,1,1, 10'h100,8'h11,8'h41,8'h42));
    add(0, 0,0,0,0,     1,1,10'h101,8'h22, ex(0,0,0,0,0,0, 10'h100,8'h11,8'h41,8'h42));
    add(0, 0,0,0,0,     1,1,10'h101,8'h22, ex(0,1,0,0,1,1, 10'h101,8'h22,8'h41,8'h42));
    add(0, 0,0,0,0,     1,1,10'h102,8'h33, ex(0,0,0,0,0,0, 10'h101,8'h22,8'h41,8'h42));
    add(0, 0,0,0,0,     1,1,10'h102,8'h33, ex(0,1,0,0,1,1, 10'h102,8'h33,8'h41,8'h42));
    add(0, 0,0,0,0,     1,1,10'h103,8'h44, ex(0,0,0,0,0,0, 10'h102,8'h33,8'h41,8'h42));
    add(0, 0,0,0,0,     1,1,10'h103,8'h44, ex(0,1,0,0,1,1, 10'h103,8'h44,8'h41,8'h42));
    add(0, 0,0,0,0,     0,0,0,0,           ex(0,0,0,0,0,0, 10'h103,8'h44,8'h41,8'h42));
    // addr1 changes during ACC; access keeps latched 0x010
    add(0, 0,0,0,0,     1,0,10'h010,0,     ex(0,1,0,0,1,0, 10'h010,0,8'h41,8'h42));
    add(0, 0,0,0,0,     0,0,10'h020,0,     ex(0,0,0,1,0,0, 10'h010,0,8'h41,8'h50));
    add(0, 0,0,0,0,     0,0,10'h020,0,     ex(0,0,0,0,0,0, 10'h010,0,8'h41,8'h50));
    add(0, 1,0,10'h3FF,0, 0,0,0,0,         ex(1,0,0,0,1,0, 10'h3FF,0,8'h41,8'h50));
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].r0, vq[i].w0, vq[i].a0, vq[i].d0,
            vq[i].r1, vq[i].w1, vq[i].a1, vq[i].d1);
      @(posedge clk); #1;
      chk($sformatf("row%0d", i), outs, vq[i].exp);
    end
    // reset during RSP of the read to 0x3FF
    drive(0, 0,0,0,0, 0,0,0,0);
    @(posedge clk); #1;
    chk("rsp_entered", {32'h0, rvalid0, rdata0[6:0]}, {32'h0, 1'b1, 7'h3F});
    rst = 1'b1;
    #1;
    chk("rst_masks_rvalid", {34'h0, gnt0, gnt1, rvalid0, rvalid1, ram_cs, ram_wr}, 40'h0);
    @(posedge clk); #1;
    chk("rst_clears", outs, 40'h0);
    drive(0, 1,0,10'h007,0, 1,0,10'h008,0);
    @(posedge clk); #1;
    chk("idle_first_tie_port0", outs, ex(1,0,0,0,1,0, 10'h007,0,0,0));
    drive(0, 0,0,0,0, 0,0,0,0);
    @(posedge clk); #1;
    chk("read_after_reset", outs, ex(0,0,1,0,0,0, 10'h007,0,8'h47,0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
